// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared defaults for the debounce bank and its per-channel slice.
//   DEB_N      : default number of independent channels
//   DEB_CNT_W  : default width of each channel's stability counter
//   DEB_LIMIT  : default number of quiet counted cycles before out follows
// ---------------------------------------------------------------------------
package debounce_pkg;

  localparam int DEB_N     = 4;
  localparam int DEB_CNT_W = 8;
  localparam int DEB_LIMIT = 255;

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One debounced bit: a 2-flop synchronizer, a saturating stability counter,
// the registered debounced level and registered rise/fall pulses.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : synchronous reset, active low
//   i_tick   : counter qualifier (1 = count every cycle)
//   i_in     : raw asynchronous input bit
//   o_out    : debounced level, registered
//   o_stable : high while the counter sits at LIMIT
//   o_rise   : one-cycle pulse, coincident with o_out going 0->1
//   o_fall   : one-cycle pulse, coincident with o_out going 1->0
// ---------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   CNT_W   = DEB_CNT_W,
  parameter int   LIMIT   = DEB_LIMIT,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_in,
  output logic o_out,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_rise;
  logic             r_fall;

  logic             w_change;
  logic             w_atLimit;
  logic             w_nextOut;

  // Any difference between the two synchronizer stages means the input moved
  // this cycle, so the quiet-time count has to start over.
  assign w_change  = r_s1 ^ r_s2;
  assign w_atLimit = (r_cnt == LIMIT_C);
  assign w_nextOut = w_atLimit ? r_s2 : r_out;

  // Synchronizer runs every edge regardless of tick so that no input sample
  // is skipped while the counter is being throttled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_in;
      r_s2 <= r_s1;
    end
  end

  // Stability counter: cleared by any change, otherwise advanced on tick and
  // parked at LIMIT so a long-quiet input never wraps back to a low count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_change) begin
      r_cnt <= '0;
    end else if (i_tick && !w_atLimit) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Debounced level and its edge pulses are registered together, so a pulse
  // is high in exactly the cycle the new level first appears on o_out.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out  <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_out  <= w_nextOut;
      r_rise <= w_nextOut & ~r_out;
      r_fall <= ~w_nextOut & r_out;
    end
  end

  assign o_out    = r_out;
  assign o_stable = w_atLimit;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

endmodule

// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// debounce_bank
// N independent debounce channels sharing one clock, reset and tick.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous reset, active low
//   tick   : counter qualifier shared by all channels
//   in     : raw asynchronous inputs, bit i = channel i
//   out    : debounced levels, registered
//   stable : per-channel "counter at LIMIT" flag
//   rise   : per-channel one-cycle pulse on out 0->1
//   fall   : per-channel one-cycle pulse on out 1->0
// ---------------------------------------------------------------------------
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   N       = DEB_N,
  parameter int   CNT_W   = DEB_CNT_W,
  parameter int   LIMIT   = DEB_LIMIT,
  parameter logic RST_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] stable,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  for (genvar g = 0; g < N; g++) begin : g_chan
    debounce_channel #(
      .CNT_W   (CNT_W),
      .LIMIT   (LIMIT),
      .RST_VAL (RST_VAL)
    ) u_chan (
      .i_clk    (clk),
      .i_rst_n  (rst),
      .i_tick   (tick),
      .i_in     (in[g]),
      .o_out    (out[g]),
      .o_stable (stable[g]),
      .o_rise   (rise[g]),
      .o_fall   (fall[g])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// ---------------------------------------------------------------------------
// tb_debounce_bank
// Directed bench for debounce_bank (N=4, CNT_W=4, LIMIT=3, RST_VAL=0).
// Expected output snapshots are queued with the edge they belong to when each
// stimulus step is driven, and compared on the falling edge after that edge.
// ---------------------------------------------------------------------------
module tb_debounce_bank;

  localparam int N     = 4;
  localparam int CNT_W = 4;
  localparam int LIMIT = 3;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
    logic [3:0] outE;
    logic [3:0] stableE;
    logic [3:0] riseE;
    logic [3:0] fallE;
    string      tag;
  } expect_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [N-1:0] in;
  logic [N-1:0] out;
  logic [N-1:0] stable;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  int      cycNow    = 0;
  int      base      = 0;
  int      testCount = 0;
  int      failCount = 0;
  expect_t sb[$];

  debounce_bank #(
    .N       (N),
    .CNT_W   (CNT_W),
    .LIMIT   (LIMIT),
    .RST_VAL (1'b0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .in     (in),
    .out    (out),
    .stable (stable),
    .rise   (rise),
    .fall   (fall)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Edge counter used to timestamp expected snapshots.
  always @(posedge clk) cycNow <= cycNow + 1;

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // The next rising edge samples whatever is driven now; call it edge 0.
  task automatic markBase();
    base = cycNow + 1;
  endtask

  task automatic applyStimulus(input logic [3:0] v);
    in = v;
    markBase();
  endtask

  task automatic expectAt(input int k, input logic [3:0] mask,
                          input logic [3:0] o, input logic [3:0] s,
                          input logic [3:0] r, input logic [3:0] f,
                          input string tag);
    expect_t e;
    e.cyc = base + k; e.mask = mask;
    e.outE = o; e.stableE = s; e.riseE = r; e.fallE = f;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    testCount++;
    assert ((out & e.mask) === (e.outE & e.mask)) else begin
      failCount++;
      $error("[TB] FAIL %s out: got %b expected %b (mask %b)", e.tag, out, e.outE, e.mask);
    end
    testCount++;
    assert ((stable & e.mask) === (e.stableE & e.mask)) else begin
      failCount++;
      $error("[TB] FAIL %s stable: got %b expected %b (mask %b)", e.tag, stable, e.stableE, e.mask);
    end
    testCount++;
    assert ((rise & e.mask) === (e.riseE & e.mask)) else begin
      failCount++;
      $error("[TB] FAIL %s rise: got %b expected %b (mask %b)", e.tag, rise, e.riseE, e.mask);
    end
    testCount++;
    assert ((fall & e.mask) === (e.fallE & e.mask)) else begin
      failCount++;
      $error("[TB] FAIL %s fall: got %b expected %b (mask %b)", e.tag, fall, e.fallE, e.mask);
    end
  endtask

  // Scoreboard drain: compare every snapshot due at this edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cycNow) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held for two edges with all inputs high.
    rst  = 1'b0;
    tick = 1'b1;
    in   = 4'hF;
    base = 0;
    expectAt(1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "reset_e1");
    expectAt(2, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "reset_e2");
    waitEdges(2);

    // Release: inputs already high propagate after the full latency.
    rst = 1'b1;
    markBase();
    expectAt(1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "rel_nopulse");
    expectAt(4, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, "rel_e4");
    expectAt(5, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, "rel_e5");
    expectAt(6, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, "rel_e6");
    waitEdges(10);

    // Bring everything low again.
    applyStimulus(4'h0);
    expectAt(4, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, "all_low_e4");
    expectAt(5, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, "all_low_e5");
    expectAt(6, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, "all_low_e6");
    waitEdges(10);

    // Single step on channel 0.
    applyStimulus(4'b0001);
    expectAt(3, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "step_e3");
    expectAt(4, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, "step_e4");
    expectAt(5, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, "step_e5");
    expectAt(6, 4'hF,    4'b0001, 4'hF,    4'b0000, 4'b0000, "step_e6");
    waitEdges(10);

    // Channel 1 pulse of LIMIT cycles must be rejected.
    applyStimulus(4'b0011);
    expectAt(4, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "glitch3_e4");
    expectAt(5, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "glitch3_e5");
    expectAt(8, 4'b0011, 4'b0001, 4'b0011, 4'b0000, 4'b0000, "glitch3_e8");
    waitEdges(3);
    in = 4'b0001;
    waitEdges(12);

    // Channel 1 pulse of LIMIT+1 cycles must propagate, then fall back.
    applyStimulus(4'b0011);
    expectAt(4, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, "pulse4_e4");
    expectAt(5, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, "pulse4_e5");
    expectAt(8, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, "pulse4_e8");
    expectAt(9, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, "pulse4_e9");
    expectAt(10, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, "pulse4_e10");
    waitEdges(4);
    in = 4'b0001;
    waitEdges(12);

    // Tick held low: channel 2 never reaches LIMIT.
    tick = 1'b0;
    applyStimulus(4'b0101);
    expectAt(5, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "tick0_e5");
    expectAt(9, 4'b0101, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "tick0_e9");
    waitEdges(11);

    // Tick every second cycle: three ticks land on edges 0, 2, 4.
    markBase();
    expectAt(4, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, "tick2_e4");
    expectAt(5, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, "tick2_e5");
    expectAt(9, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, "tick2_e9");
    for (int j = 0; j < 12; j++) begin
      tick = (j % 2 == 0);
      waitEdges(1);
    end
    tick = 1'b1;

    // Drop channel 2 back to low before the simultaneous case.
    applyStimulus(4'b0001);
    expectAt(5, 4'hF, 4'b0001, 4'hF, 4'b0000, 4'b0100, "ch2_low_e5");
    waitEdges(10);

    // Channel 0 falls and channel 3 rises on the same edge.
    applyStimulus(4'b1000);
    expectAt(4, 4'hF, 4'b0001, 4'hF, 4'b0000, 4'b0000, "simul_e4");
    expectAt(5, 4'hF, 4'b1000, 4'hF, 4'b1000, 4'b0001, "simul_e5");
    expectAt(6, 4'hF, 4'b1000, 4'hF, 4'b0000, 4'b0000, "simul_e6");
    waitEdges(10);

    // Reset on edge 3 of a channel 0 step aborts the count.
    applyStimulus(4'b1001);
    expectAt(3, 4'hF, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "midrst_e3");
    expectAt(4, 4'hF, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "midrst_e4");
    expectAt(6, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "midrst_e6");
    expectAt(8, 4'hF, 4'b0000, 4'hF, 4'b0000, 4'b0000, "midrst_e8");
    expectAt(9, 4'hF, 4'b1001, 4'hF, 4'b1001, 4'b0000, "midrst_e9");
    expectAt(10, 4'hF, 4'b1001, 4'hF, 4'b0000, 4'b0000, "midrst_e10");
    waitEdges(3);
    rst = 1'b0;
    waitEdges(1);
    rst = 1'b1;
    waitEdges(10);

    // Anything still queued was never compared.
    waitEdges(2);
    while (sb.size() != 0) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL %s not_checked: due at edge %0d, now %0d", sb[0].tag, sb[0].cyc, cycNow);
      void'(sb.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
